stopwatch_counter: RTL
======================

Name: stopwatch_counter

Overview:
Downstream consumer of the 10 Hz timebase pulse (one clk-wide tick per 100 ms) produced by the prescaler stage. It is the stopwatch core for the DE0 4-digit display:
- counts M:SS.t in BCD, range 0:00.0 to 9:59.9;
- is controlled by two debounced push buttons (start/stop, lap/reset);
- drives four BCD digits to the 7-segment decoder stage.

Parameters:
SYNC_STAGES, 2, number of flip-flop synchroniser stages on each button input (minimum 2).
MIN_MAX, 9, terminal value of the minutes digit. Wrap occurs after MIN_MAX:59.9.

Ports:
clk  in  1  system clock, 50 MHz.
rst_n  in  1  asynchronous active-low reset.
tick  in  1  one-clk-wide count enable, 10 Hz, from the timebase stage.
btn_ss_n  in  1  start/stop button, active-low level, debounced upstream, asynchronous to clk.
btn_lr_n  in  1  lap/reset button, active-low level, debounced upstream, asynchronous to clk.
dig0  out  4  tenths of seconds, BCD 0-9.
dig1  out  4  seconds ones, BCD 0-9.
dig2  out  4  seconds tens, BCD 0-5.
dig3  out  4  minutes, BCD 0-MIN_MAX.
running  out  1  high in RUN and LAP.
lap_hold  out  1  high in LAP (display frozen).
wrap  out  1  one-clk pulse when the count rolls from MIN_MAX:59.9 to 0:00.0.

Behaviour:
- Reset: clk and rst_n, with reset asynchronous and active-low. While rst_n=0: all counters 0, lap latch 0, state IDLE, all outputs 0, synchroniser stages preset to 1 (released).
- Button path: SYNC_STAGES-flop synchroniser, then a previous-value register.
  - Press event = registered value 1 while the synchronised value is 0 (falling edge).
  - With SYNC_STAGES=2, the state update lands on the 3rd rising clk edge after the pin falls.
  - Holding a button gives exactly one event. Release gives none.
- States and transitions on events:
  - IDLE: ss -> RUN. lr -> IDLE (no effect).
  - RUN: ss -> STOP. lr -> LAP, copying the live count into the lap latch on the same edge.
  - LAP: ss -> STOP, display returns to live count. lr -> RUN (display live).
  - STOP: ss -> RUN (resume). lr -> IDLE, clearing the count to 0:00.0 on the same edge.
- Simultaneous ss and lr events in one cycle: ss wins and lr is discarded.
- Counting:
  - Increments on a clk edge where tick=1 and the current (pre-update) state is RUN or LAP.
  - A tick coincident with the IDLE->RUN edge is not counted.
  - A tick coincident with the RUN->STOP edge is counted.
- Digit chain: ripple-carry enable.
  - dig0 wraps 9->0 and carries.
  - dig1 wraps 9->0 and carries.
  - dig2 wraps 5->0 and carries.
  - dig3 wraps MIN_MAX->0 and raises wrap.
  - All digit updates in one count occur on the same edge. Counting continues after wrap.
- Output latency: digits change on the clk edge that samples tick=1. Outputs are registered, with no combinational path from tick.
- Display mux: in LAP, dig0-3 = lap latch. Otherwise dig0-3 = live count. In LAP the live count keeps advancing.
- Clear on lr from STOP takes priority over a coincident tick (which is not counted in STOP anyway).
- Reset mid-count returns everything to 0 immediately, independent of clk.
- Digits never hold non-BCD values. Illegal state encodings recover to IDLE.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, RUN, STOP, LAP), 2 bits;
  - BCD width constant (4);
  - digit terminal constants (9, 5).
- One natural sub-module: bcd_digit.
  - Parameter: terminal value.
  - Ports: clk, rst_n, clr, en (carry-in), q[3:0], co.
  - co = en and q==terminal.
  - Instantiated four times, chained.
- Synchroniser/edge detector is inline. It does not warrant its own module.

Test Plan:
- Reset, then press ss, then 25 ticks: display 0:02.5, running=1. Tick coincident with the start edge is not counted.
- From 0:09.9 in RUN, one tick: display 0:10.0. From 0:59.9, one tick: display 1:00.0.
- From 9:59.9 with MIN_MAX=9, one tick: display 0:00.0 and wrap=1 for exactly one clk. The next tick gives 0:00.1.
- Lap sequence:
  - RUN at 0:03.0, press lr: lap_hold=1, display frozen at 0:03.0.
  - 20 further ticks: display still 0:03.0.
  - press lr: display 0:05.0, lap_hold=0.
- Stop/clear sequence:
  - RUN at 0:01.7, press ss: STOP. 10 ticks: display stays 0:01.7.
  - press lr: IDLE, display 0:00.0, running=0.
- Edge cases:
  - Both buttons fall on the same cycle in RUN: STOP, lap latch unchanged.
  - Button held 1000 clks: single event.
  - rst_n pulsed low mid-count at 0:42.3, async to clk: outputs 0 before the next clk edge.

Source files
------------

// File: rtl/stopwatch_counter_pkg.sv
// rtl/stopwatch_counter_pkg.sv - shared state encoding and BCD constants for the stopwatch core
package stopwatch_counter_pkg;

    localparam int BCD_W = 4;

    localparam int DIG_TERM_9 = 9;
    localparam int DIG_TERM_5 = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_LAP  = 2'd3
    } sw_state_t;

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// rtl/stopwatch_counter_bcd_digit.sv - one BCD digit with terminal wrap and carry out
module bcd_digit
    import stopwatch_counter_pkg::*;
#(
    parameter int TERM = DIG_TERM_9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [BCD_W-1:0] q,
    output logic             co
);

    localparam logic [BCD_W-1:0] TERM_V = BCD_W'(TERM);

    assign co = en && (q == TERM_V);

    // Anything at or past the terminal wraps to 0, so a corrupted digit self-heals.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            if (q >= TERM_V) begin
                q <= '0;
            end else begin
                q <= q + BCD_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - M:SS.t BCD stopwatch core with start/stop and lap/reset control
module stopwatch_counter
    import stopwatch_counter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_MAX     = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_ss_n,
    input  logic       btn_lr_n,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic       running,
    output logic       lap_hold,
    output logic       wrap
);

    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic                   ss_prev;
    logic                   lr_prev;
    logic                   ss_ev;
    logic                   lr_ev;

    sw_state_t state;

    logic [BCD_W-1:0]   live0, live1, live2, live3;
    logic               co0, co1, co2, co3;
    logic [4*BCD_W-1:0] lap_q;
    logic               count_en;
    logic               clr_cnt;
    logic               lap_load;

    // Stages reset to 1 so a reset release never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync <= '1;
            lr_sync <= '1;
            ss_prev <= 1'b1;
            lr_prev <= 1'b1;
        end else begin
            ss_sync <= {ss_sync[SYNC_STAGES-2:0], btn_ss_n};
            lr_sync <= {lr_sync[SYNC_STAGES-2:0], btn_lr_n};
            ss_prev <= ss_sync[SYNC_STAGES-1];
            lr_prev <= lr_sync[SYNC_STAGES-1];
        end
    end

    // Start/stop wins over a coincident lap/reset press.
    assign ss_ev = ss_prev & ~ss_sync[SYNC_STAGES-1];
    assign lr_ev = lr_prev & ~lr_sync[SYNC_STAGES-1] & ~ss_ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            running  <= 1'b0;
            lap_hold <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ss_ev) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ss_ev) begin
                        state   <= ST_STOP;
                        running <= 1'b0;
                    end else if (lr_ev) begin
                        state    <= ST_LAP;
                        lap_hold <= 1'b1;
                    end
                end
                ST_LAP: begin
                    if (ss_ev) begin
                        state    <= ST_STOP;
                        running  <= 1'b0;
                        lap_hold <= 1'b0;
                    end else if (lr_ev) begin
                        state    <= ST_RUN;
                        lap_hold <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (ss_ev) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end else if (lr_ev) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    running  <= 1'b0;
                    lap_hold <= 1'b0;
                end
            endcase
        end
    end

    // Gated on the pre-update state: the start edge is not counted, the stop edge is.
    assign count_en = tick && ((state == ST_RUN) || (state == ST_LAP));
    assign clr_cnt  = lr_ev && (state == ST_STOP);
    assign lap_load = lr_ev && (state == ST_RUN);

    bcd_digit #(.TERM(DIG_TERM_9)) u_dig0 (
        .clk(clk), .rst_n(rst_n), .clr(clr_cnt), .en(count_en), .q(live0), .co(co0)
    );
    bcd_digit #(.TERM(DIG_TERM_9)) u_dig1 (
        .clk(clk), .rst_n(rst_n), .clr(clr_cnt), .en(co0), .q(live1), .co(co1)
    );
    bcd_digit #(.TERM(DIG_TERM_5)) u_dig2 (
        .clk(clk), .rst_n(rst_n), .clr(clr_cnt), .en(co1), .q(live2), .co(co2)
    );
    bcd_digit #(.TERM(MIN_MAX)) u_dig3 (
        .clk(clk), .rst_n(rst_n), .clr(clr_cnt), .en(co2), .q(live3), .co(co3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_q <= '0;
            wrap  <= 1'b0;
        end else begin
            if (lap_load) begin
                lap_q <= {live3, live2, live1, live0};
            end
            wrap <= co3;
        end
    end

    assign dig0 = lap_hold ? lap_q[BCD_W-1:0]         : live0;
    assign dig1 = lap_hold ? lap_q[2*BCD_W-1:BCD_W]   : live1;
    assign dig2 = lap_hold ? lap_q[3*BCD_W-1:2*BCD_W] : live2;
    assign dig3 = lap_hold ? lap_q[4*BCD_W-1:3*BCD_W] : live3;

endmodule
